message_scroller: RTL and testbench
===================================

// Module: message_scroller
// PURPOSE
//   Character source for the four-digit seven-segment driver. It holds a fixed 16-digit hex message
//   and presents a four-digit window of it as char3..char0. char3 is the leftmost digit.
//   The window advances by one digit on each debounced push-button press or on a periodic auto-scroll tick.
//   Sits directly upstream of the LED driver; char3..char0 feed its per-digit character inputs.
// PARAMETERS
//   MESSAGE          64'h0123456789ABCDEF  message digits; digit k = MESSAGE[63-4k -: 4], k = 0..15
//   DEBOUNCE_CYCLES  16'd50000             consecutive stable samples needed to accept a button level change (>=2)
//   SCROLL_CYCLES    32'd25000000          auto-scroll period in clk cycles (>=2)
// PORTS
//   clk          in   1  single system clock; all logic on posedge clk
//   reset        in   1  synchronous, active-low reset (0 = reset)
//   button       in   1  raw asynchronous push-button, active-high, may bounce
//   auto_en      in   1  1 = periodic auto-scroll enabled
//   char3        out  4  digit at offset
//   char2        out  4  digit at (offset+1) mod 16
//   char1        out  4  digit at (offset+2) mod 16
//   char0        out  4  digit at (offset+3) mod 16
//   offset       out  4  current window start index
//   step_pulse   out  1  one-cycle strobe, high in the cycle an advance is committed
// BEHAVIOUR
//   Reset (reset==0 at a posedge): every register is cleared.
//   - Reset values: offset=0, char3..0 = digits 0,1,2,3, step_pulse=0.
//   - Synchronizer flops, debounced level, edge history and debounce counter all = 0.
//   - Tick counter = SCROLL_CYCLES-1.
//   - Reset takes priority over every other event. Any debounce or tick in progress is discarded.
//   Synchronizer: button passes through 2 flops (sync1 -> sync2) before any use.
//   Debouncer FSM: states STABLE and COUNTING.
//   - STABLE: sync2 == db_level. Counter held at 0.
//   - STABLE -> COUNTING when sync2 != db_level.
//   - COUNTING: the counter increments while sync2 != db_level.
//   - If sync2 returns to db_level, go back to STABLE and clear the counter. The glitch is rejected.
//   - When the counter reaches DEBOUNCE_CYCLES-1 and sync2 still differs: db_level toggles, counter clears, go to STABLE.
//   Press detect: btn_step = db_level & ~db_level_q (db_level_q is db_level delayed 1 cycle). Releases do nothing.
//   Auto tick: a down-counter, width $clog2(SCROLL_CYCLES).
//   - auto_en==0: the counter reloads SCROLL_CYCLES-1 every cycle and no tick is produced.
//   - auto_en==1: the counter decrements each cycle.
//   - At 0 it raises tick for 1 cycle and reloads, giving one tick every SCROLL_CYCLES cycles.
//   Advance: step = btn_step | tick.
//   - If both are true in the same cycle, the window advances by exactly 1, not 2.
//   - step_pulse is registered: it is high in the cycle after step is true.
//   - offset and char3..0 update on the same edge that raises step_pulse, so the outputs stay consistent.
//   - offset is 4-bit modulo 16: 15 -> 0. Char indices wrap mod 16 (offset 14 -> digits 14,15,0,1).
//   - All outputs are registered. There are no combinational paths from inputs to outputs.
//   Latency: a clean press first sampled at edge E gives:
//   - db_level = 1 after edge E+1+DEBOUNCE_CYCLES;
//   - step_pulse high in the cycle after edge E+2+DEBOUNCE_CYCLES;
//   - exactly one pulse per press, however long the button is held.
// STRUCTURE
//   Shared package (disp_pkg): CHAR_W=4 and NUM_DIGITS=4, the same constants the LED driver uses.
//   Also in the package: the debouncer state enum {DB_STABLE, DB_COUNTING}.
//   Sub-module: button_debounce (clk, reset, raw_in, level_out, rise_pulse).
//   - It contains the synchronizer, the debouncer FSM and the edge detect.
//   The top level holds the tick counter, the step merge, the offset register and the digit-select muxes.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, SCROLL_CYCLES=8, default MESSAGE)
//   1 reset low 3 cycles, then high -> offset=0, chars 0,1,2,3, step_pulse=0.
//     Button held 0 -> outputs unchanged for 100 cycles.
//   2 clean press, button=1 for 20 cycles -> exactly one step_pulse, 7 cycles after first sample.
//     Then chars 1,2,3,4 and offset=1. Release -> no pulse.
//   3 bounce: button toggles 1,0,1,0 with high runs of 3 cycles, then stays 0 -> no step_pulse, offset unchanged.
//   4 auto_en=1 for 128 cycles -> 16 step_pulses, each 8 cycles apart, offset back to 0.
//     At offset=13 the chars are D,E,F,0.
//   5 auto tick and debounced press committing in the same cycle -> offset +1 only, one step_pulse.
//   6 reset asserted mid-debounce (counter=2) while the button is held -> no step after reset.
//     Next press after release -> a normal single step from offset 0.

Source files
------------

// File: rtl/disp_pkg.sv
// Constants and types shared by the message scroller and the seven-segment LED driver.
package disp_pkg;

   localparam int CHAR_W     = 4;
   localparam int NUM_DIGITS = 4;

   typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;

   // Digit k of a 16-digit message; digit 0 is the most significant nibble.
   function automatic logic [CHAR_W-1:0] msg_digit(input logic [63:0] msg, input logic [3:0] idx);
      return msg[63 - CHAR_W*int'(idx) -: CHAR_W];
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, counting debouncer and rising-edge detect for one raw push-button.
module button_debounce
   import disp_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic level_out,
   output logic rise_pulse
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_level_q;
   logic [CNT_W-1:0] r_cnt;
   db_state_t        r_state;

   // NOTE: every flop here uses <= so each one samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_q <= 1'b0;
         r_cnt     <= '0;
         r_state   <= DB_STABLE;
      end else begin
         r_sync1   <= raw_in;
         r_sync2   <= r_sync1;
         r_level_q <= r_level;
         case (r_state)
            DB_STABLE: begin
               if (r_sync2 != r_level) begin
                  r_state <= DB_COUNTING;
                  r_cnt   <= CNT_W'(1);
               end else begin
                  r_cnt   <= '0;
               end
            end
            DB_COUNTING: begin
               // A sample matching the accepted level means the change was a glitch.
               if (r_sync2 == r_level) begin
                  r_state <= DB_STABLE;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_level <= ~r_level;
                  r_state <= DB_STABLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= DB_STABLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign level_out  = r_level;
   assign rise_pulse = r_level & ~r_level_q;

endmodule

// File: rtl/message_scroller.sv
// Presents a scrolling four-digit window of a fixed 16-digit hex message to the LED driver.
module message_scroller
   import disp_pkg::*;
#(
   parameter logic [63:0] MESSAGE         = 64'h0123456789ABCDEF,
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [31:0] SCROLL_CYCLES   = 32'd25000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              button,
   input  logic              auto_en,
   output logic [CHAR_W-1:0] char3,
   output logic [CHAR_W-1:0] char2,
   output logic [CHAR_W-1:0] char1,
   output logic [CHAR_W-1:0] char0,
   output logic [3:0]        offset,
   output logic              step_pulse
);

   localparam int               TICK_W      = $clog2(SCROLL_CYCLES);
   localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(SCROLL_CYCLES - 32'd1);

   logic              w_db_level;
   logic              w_db_rise;
   logic              w_btn_step;
   logic              w_tick;
   logic              w_step;
   logic [3:0]        w_next_offset;
   logic [TICK_W-1:0] r_tick_cnt;
   logic [3:0]        r_offset;
   logic              r_step_pulse;
   logic [CHAR_W-1:0] r_chars [NUM_DIGITS];

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .raw_in     (button),
      .level_out  (w_db_level),
      .rise_pulse (w_db_rise)
   );

   assign w_btn_step = w_db_rise & w_db_level;

   always_ff @(posedge clk) begin
      if (!reset || !auto_en || r_tick_cnt == '0) r_tick_cnt <= TICK_RELOAD;
      else                                         r_tick_cnt <= r_tick_cnt - TICK_W'(1);
   end

   assign w_tick        = auto_en && (r_tick_cnt == '0);
   // A press and a tick in the same cycle merge into a single advance.
   assign w_step        = w_btn_step | w_tick;
   assign w_next_offset = r_offset + 4'd1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_offset     <= '0;
         r_step_pulse <= 1'b0;
         // NOTE: r_chars is a small flop array, not a RAM, so it can take a reset value.
         for (int i = 0; i < NUM_DIGITS; i++) r_chars[i] <= msg_digit(MESSAGE, 4'(i));
      end else begin
         r_step_pulse <= w_step;
         if (w_step) begin
            r_offset <= w_next_offset;
            for (int i = 0; i < NUM_DIGITS; i++) r_chars[i] <= msg_digit(MESSAGE, w_next_offset + 4'(i));
         end
      end
   end

   assign char3      = r_chars[0];
   assign char2      = r_chars[1];
   assign char1      = r_chars[2];
   assign char0      = r_chars[3];
   assign offset     = r_offset;
   assign step_pulse = r_step_pulse;

endmodule

// File: tb/tb_message_scroller.sv
// Directed bench for message_scroller: expected steps are queued at stimulus time and matched on each step_pulse.
module tb_message_scroller;

   localparam logic [63:0] MSG = 64'h0123456789ABCDEF;
   localparam int          DEB = 4;
   localparam int          SCR = 8;

   logic       clk     = 1'b0;
   logic       reset   = 1'b0;
   logic       button  = 1'b0;
   logic       auto_en = 1'b0;
   logic [3:0] char3, char2, char1, char0, offset;
   logic       step_pulse;

   int         cyc    = 0;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_off = 4'd0;

   typedef struct {
      int         at_cyc;
      logic [3:0] off;
   } exp_t;
   exp_t sb[$];

   message_scroller #(
      .MESSAGE         (MSG),
      .DEBOUNCE_CYCLES (16'(DEB)),
      .SCROLL_CYCLES   (32'(SCR))
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .button     (button),
      .auto_en    (auto_en),
      .char3      (char3),
      .char2      (char2),
      .char1      (char1),
      .char0      (char0),
      .offset     (offset),
      .step_pulse (step_pulse)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] window(input logic [3:0] off);
      logic [15:0] w = '0;
      logic [63:0] m;
      int          idx;
      for (int k = 0; k < 4; k++) begin
         idx = (int'(off) + k) % 16;
         m   = MSG >> (60 - 4*idx);
         w   = {w[11:0], m[3:0]};
      end
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_step(input int at_cyc);
      exp_t e;
      exp_off  = exp_off + 4'd1;
      e.at_cyc = at_cyc;
      e.off    = exp_off;
      sb.push_back(e);
   endtask

   // Every observed pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (step_pulse === 1'b1) begin
         check("pulse_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pulse_cycle", cyc, e.at_cyc);
            check("pulse_offset", offset, e.off);
            check("pulse_chars", {char3, char2, char1, char0}, window(e.off));
         end
      end
   end

   initial begin
      // 1: reset and idle
      cycles(3);
      reset = 1'b1;
      check("rst_offset", offset, 0);
      check("rst_chars", {char3, char2, char1, char0}, window(4'd0));
      check("rst_step", step_pulse, 0);
      cycles(100);
      check("idle_offset", offset, 0);
      check("idle_chars", {char3, char2, char1, char0}, window(4'd0));

      // 2: clean press, held, then released
      expect_step(cyc + 3 + DEB);
      button = 1'b1;
      cycles(20);
      button = 1'b0;
      cycles(20);
      check("press_offset", offset, 1);
      check("press_chars", {char3, char2, char1, char0}, 16'h1234);
      check("press_drained", sb.size(), 0);

      // 3: bounce with high runs one sample short of acceptance
      button = 1'b1; cycles(3);
      button = 1'b0; cycles(2);
      button = 1'b1; cycles(3);
      button = 1'b0; cycles(20);
      check("bounce_offset", offset, 1);

      // 4: full auto-scroll lap from a fresh reset
      reset = 1'b0;
      cycles(3);
      reset   = 1'b1;
      exp_off = 4'd0;
      check("lap_start_offset", offset, 0);
      auto_en = 1'b1;
      for (int k = 1; k <= 16; k++) expect_step(cyc + k*SCR);
      cycles(13*SCR);
      check("lap_off13", offset, 13);
      check("lap_chars13", {char3, char2, char1, char0}, 16'hDEF0);
      cycles(3*SCR);
      auto_en = 1'b0;
      cycles(4);
      check("lap_end_offset", offset, 0);
      check("lap_drained", sb.size(), 0);

      // 5: press and tick land in the same cycle
      auto_en = 1'b1;
      cycles(1);
      button = 1'b1;
      expect_step(cyc + 3 + DEB);
      cycles(SCR - 1);
      auto_en = 1'b0;
      cycles(12);
      button = 1'b0;
      cycles(20);
      check("merge_offset", offset, 1);
      check("merge_drained", sb.size(), 0);

      // 6: reset in the middle of a debounce
      button = 1'b1;
      cycles(4);
      reset = 1'b0;
      cycles(2);
      button = 1'b0;
      cycles(2);
      reset   = 1'b1;
      exp_off = 4'd0;
      check("midrst_offset", offset, 0);
      check("midrst_chars", {char3, char2, char1, char0}, window(4'd0));
      check("midrst_step", step_pulse, 0);
      cycles(20);
      check("midrst_quiet", offset, 0);
      expect_step(cyc + 3 + DEB);
      button = 1'b1;
      cycles(15);
      button = 1'b0;
      cycles(20);
      check("after_rst_offset", offset, 1);
      check("after_rst_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
